// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_driver
// Brief    : Time-multiplexed driver for NUM_DIGITS active-low common-anode
//            seven-segment digits. Double-buffered hex value with tear-free
//            commits at frame boundaries, per-slot anti-ghosting blanking and
//            optional leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_DIV_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_BLANK    = c_DIV_W'(BLANK_CYC);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]         c_SEG_OFF  = 7'h7F;

    logic [c_DIV_W-1:0]      r_div_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pending_valid;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_div_wrap;
    logic                    w_boundary;
    logic                    w_commit;
    logic [3:0]              w_nib;
    logic                    w_zero_above;
    logic                    w_lz_blank;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_an;

    // Active-low hex glyphs, bit order g..a
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
    assign w_boundary = enable && w_div_wrap && (r_idx == c_IDX_LAST);
    // While dark, commit every cycle so a load is never left waiting
    assign w_commit   = w_boundary || !enable;

    // Select the current digit's nibble and whether it and all digits above are zero
    always_comb begin
        logic run;
        w_nib        = 4'h0;
        w_zero_above = 1'b0;
        run          = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run = run && (r_active[4*i +: 4] == 4'h0);
            if (r_idx == c_IDX_W'(i)) begin
                w_nib        = r_active[4*i +: 4];
                w_zero_above = run;
            end
        end
    end

    // Segment and anode patterns for the current counter state
    always_comb begin
        w_lz_blank = blank_lz && (r_idx != '0) && w_zero_above;
        w_seg      = c_SEG_OFF;
        if (enable && !w_lz_blank) begin
            w_seg = hex7(w_nib);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an[i] = !(enable && (r_div_cnt >= c_BLANK) && (r_idx == c_IDX_W'(i)));
        end
    end

    // Slot and digit counters; held at zero while disabled
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Double buffer: loads go to pending, a load in the commit cycle bypasses it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_commit) begin
            if (load) begin
                r_active        <= value;
                r_pending_valid <= 1'b0;
            end else if (r_pending_valid) begin
                r_active        <= r_pending;
                r_pending_valid <= 1'b0;
            end
        end else if (load) begin
            r_pending       <= value;
            r_pending_valid <= 1'b1;
        end
    end

    // Registered pin outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg        <= c_SEG_OFF;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg;
            r_an         <= w_an;
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_scan_driver
// Brief    : Directed self-checking bench for ssd_scan_driver (4 digits,
//            8-cycle slots, 2 blank cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // g..a, active low
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input bit lz, input int d);
        logic [15:0] hi;
        hi = v >> (4 * d);
        if (lz && d > 0 && hi == 16'h0) return 7'h7F;
        return seg_tab[v[4*d +: 4]];
    endfunction

    // Walk nsteps edges from a frame start, expecting value v on the display;
    // optional loads at steps s1..s3 (0 = unused)
    task automatic scan(input logic [15:0] v, input bit lz, input int nsteps,
                        input int s1, input logic [15:0] v1,
                        input int s2, input logic [15:0] v2,
                        input int s3, input logic [15:0] v3);
        int c, idx, dv;
        logic [3:0] ean;
        for (int n = 1; n <= nsteps; n++) begin
            blank_lz = lz;
            load = 1'b0;
            if (n == s1) begin load = 1'b1; value = v1; end
            if (n == s2) begin load = 1'b1; value = v2; end
            if (n == s3) begin load = 1'b1; value = v3; end
            step();
            load = 1'b0;
            c   = n - 1;
            idx = c / RD;
            dv  = c % RD;
            ean = (dv >= BC) ? ~(4'b0001 << idx) : 4'hF;
            check($sformatf("an v=%h n=%0d", v, n), an, ean);
            check($sformatf("seg v=%h n=%0d", v, n), seg, exp_seg(v, lz, idx));
            check($sformatf("fd v=%h n=%0d", v, n), frame_done, (c == ND*RD-1));
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_fd", frame_done, 1'b0);

        // Enable with nothing loaded: all zeros, frame_done every 32 cycles
        reset  = 1'b0;
        enable = 1'b1;
        scan(16'h0000, 0, 32, 0, 0, 0, 0, 0, 0);
        // Mid-frame load held back until the boundary
        scan(16'h0000, 0, 32, 10, 16'h12AF, 0, 0, 0, 0);
        scan(16'h12AF, 0, 32, 5, 16'h0007, 0, 0, 0, 0);
        // Leading-zero suppression on and off, then all-zero value
        scan(16'h0007, 1, 32, 0, 0, 0, 0, 0, 0);
        scan(16'h0007, 0, 32, 7, 16'h0000, 0, 0, 0, 0);
        scan(16'h0000, 1, 32, 0, 0, 0, 0, 0, 0);
        // Last load wins; load in the boundary cycle bypasses pending
        scan(16'h0000, 0, 32, 3, 16'h1111, 20, 16'h2222, 32, 16'h3333);
        scan(16'h3333, 0, 32, 0, 0, 0, 0, 0, 0);

        // Reset during slot 2 with a pending value and a simultaneous load
        scan(16'h3333, 0, 20, 5, 16'h4444, 0, 0, 0, 0);
        reset = 1'b1;
        load  = 1'b1;
        value = 16'h5555;
        step();
        reset = 1'b0;
        load  = 1'b0;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_fd", frame_done, 1'b0);
        scan(16'h0000, 0, 32, 0, 0, 0, 0, 0, 0);
        scan(16'h0000, 0, 32, 0, 0, 0, 0, 0, 0);

        // Dark for 20 cycles with a load, then restart from digit 0
        enable = 1'b0;
        load   = 1'b1;
        value  = 16'hBEEF;
        for (int n = 1; n <= 20; n++) begin
            step();
            load = 1'b0;
            check($sformatf("dis_an n=%0d", n), an, 4'hF);
            check($sformatf("dis_seg n=%0d", n), seg, 7'h7F);
            check($sformatf("dis_fd n=%0d", n), frame_done, 1'b0);
        end
        enable = 1'b1;
        scan(16'hBEEF, 0, 32, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
